network_mul_acc_pipe: RTL and testbench

NETWORK_MUL_ACC_PIPE -- requirements
Module: network_mul_acc_pipe

---
 rtl/network_mac_pkg.sv | 19 +
 rtl/network_mac_round_sat.sv | 57 +++++
 rtl/network_mul_acc_pipe.sv | 130 +++++++++++++
 tb/tb_network_mul_acc_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/network_mac_pkg.sv
// Shared defaults for the multiply-accumulate pipeline.
// Optional output saturation is selected by NETWORK_MAC_SAT_EN in the files that import this package.
package network_mac_pkg;

    localparam int DIN0_WIDTH_DEF  = 16;
    localparam int DIN1_WIDTH_DEF  = 14;
    localparam int DIN1_SIGNED_DEF = 0;
    localparam int ACC_WIDTH_DEF   = 40;
    localparam int DOUT_WIDTH_DEF  = 16;
    localparam int FRAC_SHIFT_DEF  = 8;

    // An unsigned B gains a zero sign bit, but the product still fits in DIN0+DIN1 bits.
    localparam int PROD_WIDTH_DEF  = DIN0_WIDTH_DEF + DIN1_WIDTH_DEF;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

endpackage

// File: rtl/network_mac_round_sat.sv
// Combinational round-half-up, shift and optional clamp of the accumulator.
// NETWORK_MAC_SAT_EN defined: clamp to the signed DOUT range and flag it.
// NETWORK_MAC_SAT_EN undefined: keep the low DOUT bits (wrap), flag tied low.
module network_mac_round_sat
    import network_mac_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic        [DOUT_WIDTH-1:0] dout,
    output logic                         sat
);

    // One extra bit so adding the rounding constant can never overflow.
    localparam int SW = ACC_WIDTH + 1;
    // Half an LSB of the output; collapses to zero when no shift is applied.
    localparam logic signed [SW-1:0] RND = SW'((SW'(1) << FRAC_SHIFT) >> 1);

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;

    // Round half up, then arithmetic shift down to the output scale.
    always_comb begin
        sum     = {acc[ACC_WIDTH-1], acc} + RND;
        shifted = sum >>> FRAC_SHIFT;
    end

`ifdef NETWORK_MAC_SAT_EN
    localparam logic signed [SW-1:0] MAX_V = SW'((SW'(1) << (DOUT_WIDTH - 1)) - SW'(1));
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

    // Clamp to the representable signed output range.
    always_comb begin
        dout = shifted[DOUT_WIDTH-1:0];
        sat  = 1'b0;
        if (shifted > MAX_V) begin
            dout = MAX_V[DOUT_WIDTH-1:0];
            sat  = 1'b1;
        end else if (shifted < MIN_V) begin
            dout = MIN_V[DOUT_WIDTH-1:0];
            sat  = 1'b1;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^shifted[SW-1:DOUT_WIDTH];

    // Wrap: keep only the low output bits.
    always_comb begin
        dout = shifted[DOUT_WIDTH-1:0];
        sat  = 1'b0;
    end
`endif

endmodule

// File: rtl/network_mul_acc_pipe.sv
// Four-stage multiply-accumulate: S1 operand capture, S2 product,
// S3 accumulate, S4 round/saturate output. ce=0 freezes every stage.
// Output saturation is enabled by defining NETWORK_MAC_SAT_EN.
module network_mul_acc_pipe
    import network_mac_pkg::*;
#(
    parameter int DIN0_WIDTH  = DIN0_WIDTH_DEF,
    parameter int DIN1_WIDTH  = DIN1_WIDTH_DEF,
    parameter int DIN1_SIGNED = DIN1_SIGNED_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int DOUT_WIDTH  = DOUT_WIDTH_DEF,
    parameter int FRAC_SHIFT  = FRAC_SHIFT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  sat_flag
);

    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_last_q, s1_last_d;
    logic signed [DIN0_WIDTH-1:0] s1_a_q, s1_a_d;
    logic        [DIN1_WIDTH-1:0] s1_b_q, s1_b_d;
    logic                         s2_valid_q, s2_valid_d;
    logic                         s2_last_q, s2_last_d;
    logic signed [PW-1:0]         s2_prod_q, s2_prod_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         first_q, first_d;
    logic                         s3_done_q, s3_done_d;
    logic                         out_valid_q, out_valid_d;
    logic        [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                         sat_q, sat_d;

    logic signed [PW-1:0]         a_ext, b_ext;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic        [DOUT_WIDTH-1:0] rs_dout;
    logic                         rs_sat;

    network_mac_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .acc  (acc_q),
        .dout (rs_dout),
        .sat  (rs_sat)
    );

    // Next-state for every stage, assuming the pipeline is enabled.
    always_comb begin
        a_ext = PW'(s1_a_q);
        if (DIN1_SIGNED != 0) begin
            b_ext = PW'($signed(s1_b_q));
        end else begin
            b_ext = PW'($unsigned(s1_b_q));
        end
        prod_ext = ACC_WIDTH'(s2_prod_q);

        s1_valid_d = in_valid;
        s1_last_d  = in_valid & in_last;
        s1_a_d     = din0;
        s1_b_d     = din1;

        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_prod_d  = a_ext * b_ext;

        acc_d     = acc_q;
        first_d   = first_q;
        s3_done_d = s2_valid_q & s2_last_q;
        if (s2_valid_q) begin
            acc_d   = first_q ? prod_ext : acc_q + prod_ext;
            first_d = s2_last_q;
        end

        out_valid_d = s3_done_q;
        dout_d      = dout_q;
        sat_d       = sat_q;
        if (s3_done_q) begin
            dout_d = rs_dout;
            sat_d  = rs_sat;
        end
    end

    // Pipeline registers: reset wins over ce, ce=0 holds everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_prod_q   <= '0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            s3_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
        end else if (ce) begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_prod_q   <= s2_prod_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            s3_done_q   <= s3_done_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_network_mul_acc_pipe.sv
// Bench for network_mul_acc_pipe: three instances (default, signed-B with no
// shift, unsigned-B with no shift) share stimulus; expected results are queued
// per instance when last terms are driven and popped when out_valid is consumed.
module tb_network_mul_acc_pipe;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               in_valid;
    logic               in_last;
    logic signed [15:0] din0;
    logic [13:0]        din1;
    logic [2:0]         ov;
    logic [15:0]        dout_a, dout_b, dout_c;
    logic [2:0]         sat;

    int checks   = 0;
    int failures = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] q2[$];
    longint      m_acc[3];
    bit          m_first[3];

    always #5 clk = ~clk;

    network_mul_acc_pipe dut_a (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[0]), .dout(dout_a), .sat_flag(sat[0])
    );
    network_mul_acc_pipe #(.DIN1_SIGNED(1), .FRAC_SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[1]), .dout(dout_b), .sat_flag(sat[1])
    );
    network_mul_acc_pipe #(.DIN1_SIGNED(0), .FRAC_SHIFT(0)) dut_c (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[2]), .dout(dout_c), .sat_flag(sat[2])
    );

    function automatic longint prod_of(input int k, input logic signed [15:0] a, input logic [13:0] b);
        longint bb;
        if (k == 1) bb = longint'($signed(b));
        else        bb = longint'(b);
        return longint'(a) * bb;
    endfunction

    function automatic logic [16:0] expect_of(input int k, input longint s);
        int     fs;
        longint r;
        logic [16:0] e;
        fs = (k == 0) ? 8 : 0;
        r  = s;
        if (fs > 0) r = (s + (longint'(1) << (fs - 1))) >>> fs;
        e = {1'b0, r[15:0]};
`ifdef NETWORK_MAC_SAT_EN
        if (r > 32767)       e = {1'b1, 16'h7FFF};
        else if (r < -32768) e = {1'b1, 16'h8000};
`endif
        return e;
    endfunction

    function automatic int qsize(input int k);
        if (k == 0) return q0.size();
        if (k == 1) return q1.size();
        return q2.size();
    endfunction

    task automatic push_exp(input int k, input logic [16:0] e);
        if (k == 0) q0.push_back(e);
        else if (k == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic check_out(input int k, input logic [15:0] d, input logic s);
        logic [16:0] e;
        int n;
        n = qsize(k);
        checks++;
        assert (n > 0) else begin
            failures++;
            $error("FAIL unexpected_out[%0d] observed=%0d expected=none", k, $signed(d));
        end
        if (n > 0) begin
            if (k == 0) e = q0.pop_front();
            else if (k == 1) e = q1.pop_front();
            else e = q2.pop_front();
            checks++;
            assert (d === e[15:0]) else begin
                failures++;
                $error("FAIL dout[%0d] observed=%0d expected=%0d", k, $signed(d), $signed(e[15:0]));
            end
            checks++;
            assert (s === e[16]) else begin
                failures++;
                $error("FAIL sat_flag[%0d] observed=%0b expected=%0b", k, s, e[16]);
            end
        end
    endtask

    // Scoreboard consumer: a result is taken when out_valid and ce meet at an edge.
    always @(negedge clk) begin
        if (ce && !reset) begin
            if (ov[0]) check_out(0, dout_a, sat[0]);
            if (ov[1]) check_out(1, dout_b, sat[1]);
            if (ov[2]) check_out(2, dout_c, sat[2]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k]   = 0;
            m_first[k] = 1'b1;
        end
    endtask

    task automatic term(input logic signed [15:0] a, input logic [13:0] b, input logic last);
        longint p;
        ce = 1'b1; in_valid = 1'b1; in_last = last; din0 = a; din1 = b;
        for (int k = 0; k < 3; k++) begin
            p = prod_of(k, a, b);
            m_acc[k]   = m_first[k] ? p : m_acc[k] + p;
            m_first[k] = last;
            if (last) push_exp(k, expect_of(k, m_acc[k]));
        end
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Enabled cycle with no valid term; in_last alone must be ignored.
    task automatic bubble();
        ce = 1'b1; in_valid = 1'b0; in_last = 1'b1; din0 = 16'sh1234; din1 = 14'h0ABC;
        step();
        in_last = 1'b0;
    endtask

    // Disabled cycles with garbage on the inputs that must not be accepted.
    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            ce = 1'b0; in_valid = 1'b1; in_last = 1'b1;
            din0 = 16'($urandom); din1 = 14'($urandom);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0; ce = 1'b1;
    endtask

    task automatic do_reset();
        ce = 1'b0; reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        step();
        reset = 1'b0; ce = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        int left;
        left = 30;
        ce = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        while ((qsize(0) + qsize(1) + qsize(2)) > 0 && left > 0) begin
            step();
            left--;
        end
        step();
        checks++;
        assert (left > 0) else begin
            failures++;
            $error("FAIL drain_timeout observed=%0d expected=0", qsize(0) + qsize(1) + qsize(2));
        end
    endtask

    initial begin
        logic [15:0] held;
        int          wait_left;
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
        model_reset();
        step(); step();
        reset = 1'b0;
        step();

        checks++; assert (ov === 3'b000) else begin failures++; $error("FAIL reset_out_valid observed=%b expected=000", ov); end
        checks++; assert (sat === 3'b000) else begin failures++; $error("FAIL reset_sat observed=%b expected=000", sat); end
        checks++; assert ({dout_a, dout_b, dout_c} === 48'h0) else begin failures++; $error("FAIL reset_dout observed=%h expected=0", {dout_a, dout_b, dout_c}); end

        // Single term, then a three-term dot product with a bubble.
        term(16'sd256, 14'd512, 1'b1);
        drain();
        term(16'sd100, 14'd3, 1'b0);
        bubble();
        term(-16'sd50, 14'd4, 1'b0);
        term(16'sd7, 14'd256, 1'b1);
        drain();

        // Large product: clamps with saturation, wraps without.
        term(16'sd32767, 14'd16383, 1'b1);
        drain();

        // Stall mid-sequence, then stall while the result is presented.
        term(16'sd1000, 14'd20, 1'b0);
        stall(3);
        term(-16'sd300, 14'd7, 1'b0);
        term(16'sd5, 14'd9, 1'b1);
        wait_left = 10;
        while (!ov[0] && wait_left > 0) begin
            step();
            wait_left--;
        end
        ce = 1'b0;
        checks++;
        assert (ov[0] === 1'b1) else begin failures++; $error("FAIL stall_wait observed=%b expected=1", ov[0]); end
        held = dout_a;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            assert (ov[0] === 1'b1 && dout_a === held) else begin
                failures++;
                $error("FAIL stall_hold observed=%b/%0d expected=1/%0d", ov[0], $signed(dout_a), $signed(held));
            end
        end
        drain();

        // Back-to-back single-term sequences.
        term(16'sd3, 14'd4, 1'b1);
        term(-16'sd7, 14'd100, 1'b1);
        term(16'sd12345, 14'd13, 1'b1);
        drain();

        // Interrupted sequence is discarded; only the new one emerges.
        term(16'sd11, 14'd11, 1'b0);
        term(16'sd22, 14'd22, 1'b0);
        do_reset();
        term(16'sd10, 14'd10, 1'b1);
        drain();

        // Signed vs unsigned B with an all-ones-ish pattern.
        term(-16'sd3, 14'h3FFB, 1'b1);
        drain();

        repeat (3) step();
        checks++;
        assert (ov === 3'b000) else begin failures++; $error("FAIL idle_out_valid observed=%b expected=000", ov); end
        checks++;
        assert ((qsize(0) + qsize(1) + qsize(2)) == 0) else begin
            failures++;
            $error("FAIL leftover_expected observed=%0d expected=0", qsize(0) + qsize(1) + qsize(2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
